// File: rtl/cdb_arbiter.sv
// Round-robin CDB arbiter: one registered grant per cycle, one-entry holding buffer per FU.
// Latency 1 cycle uncontended; a source is back-pressured (req_ready low) while its buffer is full.
module cdb_arbiter #(
    parameter int NUM_SRC = 4,
    parameter int PKT_W   = 32,
    parameter int SRC_W   = $clog2(NUM_SRC)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic [NUM_SRC-1:0]       req_valid,
    input  logic [NUM_SRC*PKT_W-1:0] req_data,
    output logic [NUM_SRC-1:0]       req_ready,
    output logic                     cdb_valid,
    output logic [PKT_W-1:0]         cdb_data,
    output logic [SRC_W-1:0]         cdb_src,
    output logic [15:0]              conflict_cnt
);

    typedef logic [PKT_W-1:0] cdb_t;

    logic [NUM_SRC-1:0] buf_valid;
    cdb_t               buf_data [NUM_SRC];
    logic [SRC_W-1:0]   rr_ptr;

    logic [NUM_SRC-1:0] accept;
    logic [NUM_SRC-1:0] cand;
    logic [NUM_SRC-1:0] gnt;
    cdb_t               cand_pkt [NUM_SRC];
    logic               any_cand;
    logic               multi_cand;
    logic [SRC_W-1:0]   win;
    logic [SRC_W-1:0]   rr_next;
    logic [SRC_W:0]     idx_sum;
    logic [SRC_W-1:0]   idx;

    assign req_ready  = ~buf_valid;
    assign accept     = req_valid & req_ready;
    assign cand       = buf_valid | accept;
    assign multi_cand = |(cand & (cand - NUM_SRC'(1)));

    always_comb begin
        for (int i = 0; i < NUM_SRC; i++) begin
            cand_pkt[i] = buf_valid[i] ? buf_data[i] : req_data[i*PKT_W +: PKT_W];
        end
    end

    // Scan from the farthest offset down so the candidate closest to rr_ptr is the last one written.
    always_comb begin
        any_cand = 1'b0;
        win      = '0;
        idx_sum  = '0;
        idx      = '0;
        for (int k = NUM_SRC - 1; k >= 0; k--) begin
            idx_sum = {1'b0, rr_ptr} + (SRC_W+1)'(k);
            if (idx_sum >= (SRC_W+1)'(NUM_SRC)) begin
                idx_sum = idx_sum - (SRC_W+1)'(NUM_SRC);
            end
            idx = idx_sum[SRC_W-1:0];
            if (cand[idx]) begin
                any_cand = 1'b1;
                win      = idx;
            end
        end
    end

    always_comb begin
        gnt     = any_cand ? (NUM_SRC'(1) << win) : '0;
        rr_next = (win == SRC_W'(NUM_SRC - 1)) ? '0 : win + SRC_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buf_valid    <= '0;
            cdb_valid    <= 1'b0;
            cdb_data     <= '0;
            cdb_src      <= '0;
            rr_ptr       <= '0;
            conflict_cnt <= '0;
            for (int i = 0; i < NUM_SRC; i++) begin
                buf_data[i] <= '0;
            end
        end else if (flush) begin
            buf_valid <= '0;
            cdb_valid <= 1'b0;
        end else begin
            cdb_valid <= any_cand;
            if (any_cand) begin
                cdb_data <= cand_pkt[win];
                cdb_src  <= win;
                rr_ptr   <= rr_next;
            end
            // Losing fresh packets park in the buffer; losing buffered packets simply stay.
            for (int i = 0; i < NUM_SRC; i++) begin
                if (gnt[i]) begin
                    buf_valid[i] <= 1'b0;
                end else if (accept[i]) begin
                    buf_valid[i] <= 1'b1;
                    buf_data[i]  <= req_data[i*PKT_W +: PKT_W];
                end
            end
            if (multi_cand && (conflict_cnt != 16'hFFFF)) begin
                conflict_cnt <= conflict_cnt + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Scoreboard bench for cdb_arbiter: stimulus pushes expected CDB packets, a negedge monitor pops and compares.
module tb_cdb_arbiter;

    localparam int N = 4;
    localparam int W = 32;

    logic           clk = 1'b0;
    logic           rst_n = 1'b1;
    logic           flush = 1'b0;
    logic [N-1:0]   req_valid = '0;
    logic [N*W-1:0] req_data = '0;
    logic [N-1:0]   req_ready;
    logic           cdb_valid;
    logic [W-1:0]   cdb_data;
    logic [1:0]     cdb_src;
    logic [15:0]    conflict_cnt;

    int          n_cmp = 0;
    int          n_err = 0;
    bit          mon_en = 1'b0;
    logic [33:0] exp_q[$];

    cdb_arbiter #(.NUM_SRC(N), .PKT_W(W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .flush        (flush),
        .req_valid    (req_valid),
        .req_data     (req_data),
        .req_ready    (req_ready),
        .cdb_valid    (cdb_valid),
        .cdb_data     (cdb_data),
        .cdb_src      (cdb_src),
        .conflict_cnt (conflict_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive(input int src, input logic [31:0] d);
        req_valid[src]        = 1'b1;
        req_data[src*W +: W]  = d;
    endtask

    task automatic expect_pkt(input int src, input logic [31:0] d);
        exp_q.push_back({2'(src), d});
    endtask

    // Monitor: every CDB beat must match the head of the expected queue.
    always @(negedge clk) begin
        if (mon_en && cdb_valid === 1'b1) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL cdb_unexpected: got src %0d data %h, expected no packet", cdb_src, cdb_data);
            end else begin
                logic [33:0] e;
                e = exp_q.pop_front();
                if ({cdb_src, cdb_data} !== e) begin
                    n_err++;
                    $display("FAIL cdb_pkt: got src %0d data %h, expected src %0d data %h",
                             cdb_src, cdb_data, e[33:32], e[31:0]);
                end
            end
        end
    end

    initial begin
        // Reset with traffic present
        req_valid = 4'hF;
        req_data  = {32'h3333_3333, 32'h2222_2222, 32'h1111_1111, 32'h0000_0001};
        #1 rst_n = 1'b0;
        #2;
        chk("rst_cdb_valid", 32'(cdb_valid), 32'd0);
        chk("rst_cdb_data", cdb_data, 32'd0);
        chk("rst_cdb_src", 32'(cdb_src), 32'd0);
        chk("rst_conflict", 32'(conflict_cnt), 32'd0);
        chk("rst_ready", 32'(req_ready), 32'hF);
        repeat (2) @(posedge clk);
        #1;
        req_valid = '0;
        rst_n     = 1'b1;
        mon_en    = 1'b1;
        tick(2);
        @(negedge clk);
        chk("idle_cdb_valid", 32'(cdb_valid), 32'd0);

        // All-source burst from rr_ptr = 0
        for (int i = 0; i < N; i++) begin
            drive(i, 32'hA000_0000 + 32'(i));
            expect_pkt(i, 32'hA000_0000 + 32'(i));
        end
        tick(1);
        req_valid = '0;
        @(negedge clk);
        chk("burst_ready0", 32'(req_ready), 32'b0001);
        tick(1);
        @(negedge clk);
        chk("burst_ready1", 32'(req_ready), 32'b0011);
        tick(1);
        @(negedge clk);
        chk("burst_ready2", 32'(req_ready), 32'b0111);
        tick(1);
        @(negedge clk);
        chk("burst_ready3", 32'(req_ready), 32'b1111);
        chk("burst_conflict", 32'(conflict_cnt), 32'd3);

        // Single source 2, uncontended: visible one cycle later
        drive(2, 32'hDEAD_BEEF);
        expect_pkt(2, 32'hDEAD_BEEF);
        tick(1);
        req_valid = '0;
        @(negedge clk);
        chk("single_valid", 32'(cdb_valid), 32'd1);
        chk("single_data", cdb_data, 32'hDEAD_BEEF);
        chk("single_src", 32'(cdb_src), 32'd2);
        chk("single_conflict", 32'(conflict_cnt), 32'd3);
        tick(1);
        @(negedge clk);
        chk("single_idle", 32'(cdb_valid), 32'd0);

        // Rotation: rr_ptr = 3, sources 0 and 3 together -> 3 then 0
        drive(0, 32'h0000_0C00);
        drive(3, 32'h0000_0C03);
        expect_pkt(3, 32'h0000_0C03);
        expect_pkt(0, 32'h0000_0C00);
        tick(1);
        req_valid = '0;
        @(negedge clk);
        chk("rot_ready", 32'(req_ready), 32'b1110);
        tick(1);
        @(negedge clk);
        chk("rot_ready_rel", 32'(req_ready), 32'b1111);
        chk("rot_conflict", 32'(conflict_cnt), 32'd4);
        tick(1);

        // Flush with sources 1 and 3 buffered and source 0 presenting
        drive(1, 32'h0000_00F1);
        expect_pkt(1, 32'h0000_00F1);
        tick(1);
        req_valid = '0;
        drive(1, 32'h0000_00B1);
        drive(2, 32'h0000_00B2);
        drive(3, 32'h0000_00B3);
        expect_pkt(2, 32'h0000_00B2);
        tick(1);
        req_valid = '0;
        @(negedge clk);
        chk("pre_flush_ready", 32'(req_ready), 32'b0101);
        flush = 1'b1;
        drive(0, 32'h0000_00E0);
        tick(1);
        flush     = 1'b0;
        req_valid = '0;
        @(negedge clk);
        chk("flush_cdb_valid", 32'(cdb_valid), 32'd0);
        chk("flush_ready", 32'(req_ready), 32'hF);
        chk("flush_conflict", 32'(conflict_cnt), 32'd5);
        tick(3);
        // rr_ptr must still be 3 after the flush, so source 3 beats source 0
        drive(0, 32'h0000_0D00);
        drive(3, 32'h0000_0D03);
        expect_pkt(3, 32'h0000_0D03);
        expect_pkt(0, 32'h0000_0D00);
        tick(1);
        req_valid = '0;
        tick(3);
        @(negedge clk);
        chk("post_flush_conflict", 32'(conflict_cnt), 32'd6);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);

        // Counter saturation under continuous full contention
        mon_en = 1'b0;
        for (int i = 0; i < N; i++) drive(i, 32'h5A00_0000 + 32'(i));
        tick(65540);
        @(negedge clk);
        chk("sat_conflict", 32'(conflict_cnt), 32'hFFFF);
        tick(5);
        @(negedge clk);
        chk("sat_hold", 32'(conflict_cnt), 32'hFFFF);
        chk("sat_cdb_valid", 32'(cdb_valid), 32'd1);

        // Asynchronous reset mid-cycle with traffic present
        rst_n = 1'b0;
        #1;
        chk("arst_cdb_valid", 32'(cdb_valid), 32'd0);
        chk("arst_cdb_data", cdb_data, 32'd0);
        chk("arst_cdb_src", 32'(cdb_src), 32'd0);
        chk("arst_conflict", 32'(conflict_cnt), 32'd0);
        chk("arst_ready", 32'(req_ready), 32'hF);
        tick(1);
        rst_n     = 1'b1;
        req_valid = '0;
        tick(2);
        @(negedge clk);
        chk("arst_idle", 32'(cdb_valid), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
